// File: rtl/serial_adder_driver_pkg.sv
// Shared definitions for the bit-serial adder driver: state encoding, default width and
// the pin map onto the external 1-bit fulladder.
package serial_adder_driver_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Fulladder pin IDs: inputs I_A/I_B/I_Y, outputs O_CARRY/O_SUM.
  localparam int unsigned FaInW      = 3;
  localparam int unsigned FaPinA     = 0;
  localparam int unsigned FaPinB     = 1;
  localparam int unsigned FaPinY     = 2;
  localparam int unsigned FaOutW     = 2;
  localparam int unsigned FaPinCarry = 0;
  localparam int unsigned FaPinSum   = 1;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, shift-right register with serial MSB input and async active-low clear.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_adder_driver.sv
// Drives two WIDTH-bit operands LSB-first through an external 1-bit fulladder and
// gathers the returned sum bits into a parallel result with carry and signed overflow.
module serial_adder_driver
  import serial_adder_driver_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_y,
  input  logic             fa_c,
  input  logic             fa_s
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic [FaInW-1:0]  fa_in;
  logic [FaOutW-1:0] fa_out;
  logic             accept, running;
  logic             unused_op_hi;

  assign accept  = in_valid && in_ready;
  assign running = (state_q == StRun);

  assign fa_out[FaPinCarry] = fa_c;
  assign fa_out[FaPinSum]   = fa_s;

  // Subtraction is A + ~B + ~borrow; only the operand register sees the inversion.
  serial_shift_reg #(
    .WIDTH(WIDTH)
  ) u_opa (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (a),
    .shift    (running),
    .ser_in   (1'b0),
    .q        (opa_q)
  );

  serial_shift_reg #(
    .WIDTH(WIDTH)
  ) u_opb (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (sub ? ~b : b),
    .shift    (running),
    .ser_in   (1'b0),
    .q        (opb_q)
  );

  serial_shift_reg #(
    .WIDTH(WIDTH)
  ) u_res (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .shift    (running),
    .ser_in   (fa_out[FaPinSum]),
    .q        (res_q)
  );

  assign unused_op_hi = ^{opa_q[WIDTH-1:1], opb_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        carry_d = fa_out[FaPinCarry];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Carry into the MSB, needed for signed overflow.
          msb_cin_d = carry_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    overflow  = 1'b0;
    fa_in     = '0;
    unique case (state_q)
      StIdle: in_ready = reset;
      StRun: begin
        fa_in[FaPinA] = opa_q[0];
        fa_in[FaPinB] = opb_q[0];
        fa_in[FaPinY] = carry_q;
      end
      StDone: begin
        out_valid = 1'b1;
        sum       = res_q;
        cout      = carry_q;
        overflow  = msb_cin_q ^ carry_q;
      end
      default: ;
    endcase
  end

  assign fa_a = fa_in[FaPinA];
  assign fa_b = fa_in[FaPinB];
  assign fa_y = fa_in[FaPinY];

endmodule

// File: tb/tb_serial_adder_driver.sv
// Self-checking bench for serial_adder_driver with a behavioural fulladder and an
// integer-arithmetic reference model.
module tb_serial_adder_driver;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         fa_a;
  logic         fa_b;
  logic         fa_y;
  logic         fa_c;
  logic         fa_s;

  int total;
  int bad;

  serial_adder_driver #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_y      (fa_y),
    .fa_c      (fa_c),
    .fa_s      (fa_s)
  );

  // External 1-bit fulladder.
  assign fa_s = fa_a ^ fa_b ^ fa_y;
  assign fa_c = (fa_a & fa_b) | (fa_a & fa_y) | (fa_b & fa_y);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, cout, sum} from plain signed/unsigned integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    int ua, ub, sa, sb, u, r;
    logic [W-1:0] s;
    logic c, o;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    if (msub) begin
      u = ua - ub - int'(mcin);
      r = sa - sb - int'(mcin);
      c = (u >= 0);
    end else begin
      u = ua + ub + int'(mcin);
      r = sa + sb + int'(mcin);
      c = (u >= (1 << W));
    end
    s = W'(u & ((1 << W) - 1));
    o = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    return {o, c, s};
  endfunction

  // Issue one operation from IDLE and wait (bounded) for DONE; leaves the DUT in DONE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                        input logic isub, output int lat, output logic [W-1:0] osum,
                        output logic ocout, output logic oovf, output logic [W-1:0] seq);
    seq = '0;
    a = ia;
    b = ib;
    cin = icin;
    sub = isub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (lat < W) seq[lat] = fa_a;
      tick();
      lat++;
    end
    osum = sum;
    ocout = cout;
    oovf = overflow;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({in_ready, out_valid, sum, cout, overflow, fa_a, fa_b, fa_y} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h c=%b o=%b fa=%b%b%b want all 0",
               in_ready, out_valid, sum, cout, overflow, fa_a, fa_b, fa_y);
      bad++;
    end
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
      bad++;
    end
  endtask

  task automatic test_add();
    int lat;
    logic [W-1:0] s, seq;
    logic c, o;
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat, s, c, o, seq);
    total++;
    if ({o, c, s} !== {1'b1, 1'b0, 8'h8D}) begin
      $display("FAIL add_ovf: got o=%b c=%b s=%h want o=1 c=0 s=8d", o, c, s);
      bad++;
    end
    total++;
    if (lat !== W) begin
      $display("FAIL add_latency: got %0d want %0d", lat, W);
      bad++;
    end
    release_result();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, s, c, o, seq);
    total++;
    if ({o, c, s} !== {1'b0, 1'b1, 8'h00}) begin
      $display("FAIL add_wrap: got o=%b c=%b s=%h want o=0 c=1 s=00", o, c, s);
      bad++;
    end
    total++;
    if (seq !== 8'hFF) begin
      $display("FAIL add_wrap_fa_a_seq: got %b want 11111111", seq);
      bad++;
    end
    total++;
    if ({fa_a, fa_b, fa_y} !== 3'b000) begin
      $display("FAIL done_fa_quiet: got %b%b%b want 000", fa_a, fa_b, fa_y);
      bad++;
    end
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    logic [W-1:0] s, seq;
    logic c, o;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, lat, s, c, o, seq);
    total++;
    if ({o, c, s} !== {1'b0, 1'b1, 8'h0F}) begin
      $display("FAIL sub_basic: got o=%b c=%b s=%h want o=0 c=1 s=0f", o, c, s);
      bad++;
    end
    release_result();
    run_op(8'h80, 8'h01, 1'b0, 1'b1, lat, s, c, o, seq);
    total++;
    if ({o, c, s} !== {1'b1, 1'b1, 8'h7F}) begin
      $display("FAIL sub_ovf: got o=%b c=%b s=%h want o=1 c=1 s=7f", o, c, s);
      bad++;
    end
    release_result();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] s, seq, ra, rb;
    logic c, o, rc, rs;
    logic [W+1:0] exp_v;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      exp_v = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, lat, s, c, o, seq);
      total++;
      if ({o, c, s} !== exp_v || lat !== W) begin
        $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got o=%b c=%b s=%h lat=%0d want %b %b %h lat=%0d",
                 i, ra, rb, rc, rs, o, c, s, lat, exp_v[W+1], exp_v[W], exp_v[W-1:0], W);
        bad++;
      end
      total++;
      if (seq !== ra) begin
        $display("FAIL random_fa_a_seq_%0d: got %h want %h", i, seq, ra);
        bad++;
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] s, seq;
    logic c, o;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, lat, s, c, o, seq);
    a = 8'h44;
    b = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || sum !== 8'h03 || in_ready !== 1'b0) begin
        $display("FAIL stall_hold_%0d: got vld=%b sum=%h rdy=%b want vld=1 sum=03 rdy=0",
                 i, out_valid, sum, in_ready);
        bad++;
      end
    end
    in_valid = 1'b0;
    release_result();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL stall_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      bad++;
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [W-1:0] s, seq;
    logic c, o;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({out_valid, fa_a, fa_b, fa_y, in_ready} !== 5'b0) begin
        $display("FAIL mid_reset_%0d: got vld=%b fa=%b%b%b rdy=%b want all 0",
                 i, out_valid, fa_a, fa_b, fa_y, in_ready);
        bad++;
      end
      tick();
    end
    reset = 1'b1;
    tick();
    run_op(8'h22, 8'h11, 1'b0, 1'b0, lat, s, c, o, seq);
    total++;
    if ({c, s} !== {1'b0, 8'h33} || lat !== W) begin
      $display("FAIL after_reset_op: got c=%b s=%h lat=%0d want c=0 s=33 lat=%0d", c, s, lat, W);
      bad++;
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[4];
    logic [W-1:0] pb[4];
    logic [W+1:0] exp_v;
    logic [W+1:0] got[4];
    int vcyc[4];
    int nres, next, cyc;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
    end
    nres = 0;
    next = 0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = pa[0];
    b = pb[0];
    for (cyc = 0; cyc < 80 && nres < 4; cyc++) begin
      if (out_valid) begin
        got[nres] = {overflow, cout, sum};
        vcyc[nres] = cyc;
        nres++;
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        next++;
        if (next < 4) begin
          a = pa[next];
          b = pb[next];
        end else begin
          in_valid = 1'b0;
          a = W'($urandom);
          b = W'($urandom);
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (nres !== 4) begin
      $display("FAIL b2b_count: got %0d want 4", nres);
      bad++;
    end
    for (int i = 0; i < nres; i++) begin
      exp_v = model(pa[i], pb[i], 1'b0, 1'b0);
      total++;
      if (got[i] !== exp_v) begin
        $display("FAIL b2b_result_%0d: got %h want %h", i, got[i], exp_v);
        bad++;
      end
      if (i > 0) begin
        total++;
        if (vcyc[i] - vcyc[i-1] !== W + 2) begin
          $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, vcyc[i] - vcyc[i-1], W + 2);
          bad++;
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
